stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
Parametrised multicycle control sequencer for the RISC core. It generates the one-hot per-stage enables that drive fetch, decode, execute, memory and write-back. Beyond the fixed five-state loop, it adds stage count as a parameter, stall hold, a second fetch cycle for immediate-word instructions, memory-stage skip, graceful halt and a retired-instruction counter. It sits beside the datapath and replaces ad-hoc per-stage enable logic.

Parameters:
NUM_STAGES, 5, number of pipeline stages per instruction. Stage 0 = fetch, 1 = decode, NUM_STAGES-1 = write-back. Legal range 3..8.
MEM_STAGE, 3, index of the skippable memory stage. Legal range 2..NUM_STAGES-2. 0 disables skip support.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  level; leaves IDLE when 1
halt_req  in  1  level; finish current instruction, then return to IDLE
stall  in  1  freeze the sequencer this cycle
need_imm  in  1  from decode: instruction carries a second (immediate) word; sampled in stage 1
skip_mem  in  1  from decode: no memory access; sampled in stage 1
stage_en  out  NUM_STAGES  one-hot enable of the active stage
imm_fetch  out  1  high during the extra immediate-fetch cycle
pc_inc  out  1  advance PC this cycle
retire  out  1  one-cycle pulse: instruction completes this cycle
busy  out  1  sequencer not in IDLE
instr_count  out  CNT_WIDTH  instructions retired since reset

Behaviour:
- States: IDLE, STAGE(s) for s = 0..NUM_STAGES-1, IMM.
- State, the imm/skip flags, halt_pending and instr_count are registered. All outputs are decoded from these registers.
- Reset (rst = 0, asynchronous):
  - state = IDLE, stage_en = 0, imm_fetch = 0, pc_inc = 0, retire = 0, busy = 0, instr_count = 0.
  - Flags and halt_pending cleared.
  - Reset mid-instruction abandons the instruction without a retire pulse.
- IDLE: all enables 0. If start = 1 at a clock edge, the next state is STAGE(0). halt_req is ignored in IDLE.
- stage_en[s] = 1 iff the state is STAGE(s) and stall = 0.
- IMM drives stage_en[0] = 1 and imm_fetch = 1 (when stall = 0).
- stall = 1 in any non-IDLE state:
  - State, flags and counter hold.
  - stage_en, imm_fetch, pc_inc and retire are forced to 0.
- Transitions, taken only when stall = 0:
  - STAGE(0) -> STAGE(1).
  - STAGE(1): latch need_imm and skip_mem into flags. Next state is IMM if need_imm = 1, else STAGE(2).
  - IMM -> STAGE(2).
  - STAGE(s), 2 <= s < NUM_STAGES-1 -> STAGE(s+1). Exception: if MEM_STAGE != 0, the skip flag is set and s+1 = MEM_STAGE, go to STAGE(MEM_STAGE+1). The skipped stage gets no enable.
  - STAGE(NUM_STAGES-1): retire = 1 this cycle. Next state is IDLE if halt_pending or (halt_req and not start), else STAGE(0). Flags clear.
- need_imm and skip_mem may both be set; both take effect. Cycle count is then NUM_STAGES + 1 - 1 = NUM_STAGES.
- halt_pending:
  - Set when halt_req = 1 in any non-IDLE state.
  - Cleared on entering IDLE.
  - A halt request never aborts a started instruction.
- pc_inc = 1 in STAGE(0) and in IMM when stall = 0. This gives two PC increments for an immediate instruction.
- instr_count increments by 1 on every retire and wraps from 2^CNT_WIDTH-1 to 0. No saturation.
- busy = 1 in every state except IDLE, including stalled cycles.
- Latency:
  - start to first stage_en[0]: 1 cycle.
  - Unstalled instruction: NUM_STAGES cycles, +1 with need_imm, -1 with skip_mem.
  - Back-to-back instructions have no bubble: STAGE(NUM_STAGES-1) is followed directly by STAGE(0).

Test Plan:
- Reset then start = 1 for 1 cycle, defaults, no stall -> stage_en sequence 00001, 00010, 00100, 01000, 10000, 00001 ... Retire pulses every 5 cycles; instr_count 1 after cycle 6.
- need_imm = 1 in decode -> enables 00001, 00010, 00001 (imm_fetch = 1), 00100, 01000, 10000. pc_inc high twice; 6 cycles per instruction.
- skip_mem = 1 and need_imm = 1 together -> 00001, 00010, 00001 (imm), 00100, 10000. Memory enable never seen; 5 cycles.
- stall = 1 for 3 cycles while in STAGE(2) -> stage_en = 0 and pc_inc = 0 for those 3 cycles, busy = 1. Resumes at 00100, then 01000; total instruction length 8.
- halt_req pulsed during STAGE(1) -> instruction completes, retire pulses, next state IDLE, busy = 0. instr_count unchanged afterwards until start.
- CNT_WIDTH = 4, run 17 instructions -> instr_count reaches 15, wraps to 0, ends at 1. Separately, rst = 0 during STAGE(3) -> all outputs 0 immediately (asynchronously), instr_count = 0, no retire pulse.

Source files
------------

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multicycle per-stage enable sequencer with stall, immediate fetch, memory skip and halt
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  halt_req_i,
  input  logic                  stall_i,
  input  logic                  need_imm_i,
  input  logic                  skip_mem_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic                  imm_fetch_o,
  output logic                  pc_inc_o,
  output logic                  retire_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  instr_count_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);
  localparam logic [2:0] MEM_IDX  = 3'(MEM_STAGE);
  localparam logic       SKIP_EN  = (MEM_STAGE != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAGE = 2'd1,
    S_IMM   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic                 imm_q, imm_d;
  logic                 skip_q, skip_d;
  logic                 halt_pending_q, halt_pending_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic run;
  logic at_last;
  logic go_idle;

  // Stage following s_nxt-1, hopping over the memory stage when this instruction skips it
  function automatic logic [2:0] advance(input logic [2:0] s_nxt, input logic skip);
    if (SKIP_EN && skip && (s_nxt == MEM_IDX)) begin
      return 3'(s_nxt + 3'd1);
    end
    return s_nxt;
  endfunction

  assign run     = (state_q != S_IDLE) && !stall_i;
  assign at_last = (state_q == S_STAGE) && (idx_q == LAST_IDX);
  assign go_idle = halt_pending_q || (halt_req_i && !start_i);

  // Output decode from the registered state; a stall masks every strobe but not busy
  always_comb begin
    stage_en_o    = '0;
    imm_fetch_o   = 1'b0;
    pc_inc_o      = 1'b0;
    retire_o      = 1'b0;
    busy_o        = (state_q != S_IDLE);
    instr_count_o = count_q;
    if (run) begin
      if (state_q == S_IMM) begin
        stage_en_o  = NUM_STAGES'(1);
        imm_fetch_o = 1'b1;
        pc_inc_o    = 1'b1;
      end else begin
        stage_en_o = NUM_STAGES'(1) << idx_q;
        pc_inc_o   = (idx_q == 3'd0);
        retire_o   = at_last;
      end
    end
  end

  // Next-state logic: sequence advance, decode-time flag capture and halt bookkeeping
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    imm_d          = imm_q;
    skip_d         = skip_q;
    halt_pending_d = halt_pending_q;
    count_d        = count_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_STAGE;
          idx_d   = 3'd0;
        end
      end
      S_IMM: begin
        if (!stall_i) begin
          state_d = S_STAGE;
          idx_d   = advance(3'd2, skip_q);
        end
      end
      S_STAGE: begin
        if (!stall_i) begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else if (idx_q == 3'd1) begin
            imm_d  = need_imm_i;
            skip_d = skip_mem_i;
            if (need_imm_i) begin
              state_d = S_IMM;
            end else begin
              idx_d = advance(3'd2, skip_mem_i);
            end
          end else if (at_last) begin
            imm_d  = 1'b0;
            skip_d = 1'b0;
            idx_d  = 3'd0;
            if (go_idle) begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = advance(3'(idx_q + 3'd1), skip_q);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
    if (state_q != S_IDLE) begin
      halt_pending_d = halt_pending_q | halt_req_i;
    end
    if (state_d == S_IDLE) begin
      halt_pending_d = 1'b0;
    end
    if (retire_o) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // State register with asynchronous active-low reset; an abandoned instruction never retires
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      idx_q          <= 3'd0;
      imm_q          <= 1'b0;
      skip_q         <= 1'b0;
      halt_pending_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      imm_q          <= imm_d;
      skip_q         <= skip_d;
      halt_pending_q <= halt_pending_d;
      count_q        <= count_d;
    end
  end

endmodule
